// File: rtl/video_pkg.sv
// Shared video/Wishbone constants and the SDRAM writer state type.
package video_pkg;

    localparam int HDISP_DEFAULT = 800;
    localparam int VDISP_DEFAULT = 480;
    localparam int WB_DATA_BYTES = 4;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } wr_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; rdata always shows the head word.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign rdata   = mem[rd_ptr_reg];
    assign do_pop  = pop & ~empty;
    // A push into a full FIFO is only safe when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge sys_clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/wshb_stream_writer.sv
// Accepts pixel words on a Wishbone stream slave and writes them linearly into
// an SDRAM frame buffer through a Wishbone master, buffering through a FIFO.
module wshb_stream_writer
    import video_pkg::*;
#(
    parameter int          HDISP      = HDISP_DEFAULT,
    parameter int          VDISP      = VDISP_DEFAULT,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        s_cyc,
    input  logic        s_stb,
    input  logic        s_we,
    input  logic [31:0] s_adr,
    input  logic [31:0] s_dat_ms,
    input  logic [3:0]  s_sel,
    output logic [31:0] s_dat_sm,
    output logic        s_ack,
    output logic        s_err,
    output logic        s_rty,
    output logic        m_cyc,
    output logic        m_stb,
    output logic        m_we,
    output logic [31:0] m_adr,
    output logic [31:0] m_dat_ms,
    output logic [3:0]  m_sel,
    output logic [2:0]  m_cti,
    output logic [1:0]  m_bte,
    input  logic        m_ack,
    input  logic        m_err,
    output logic        frame_done
);

    localparam int NPIX = HDISP * VDISP;
    localparam int PW   = $clog2(NPIX);
    localparam int CW   = $clog2(FIFO_DEPTH) + 1;

    wr_state_t    state_reg, state_next;
    logic [PW-1:0] pix_idx_reg, pix_idx_next;
    logic [7:0]   frame_cnt_reg, frame_cnt_next;
    logic         frame_done_reg, frame_done_next;
    logic         s_ack_reg, s_ack_next;

    logic         fifo_push;
    logic         fifo_pop;
    logic [31:0]  fifo_rdata;
    logic         fifo_full;
    logic         fifo_empty;
    logic [CW-1:0] fifo_count;
    logic         in_write;
    logic         last_pix;
    logic [31:0]  addr_off;
    logic         unused_inputs;

    // Address and byte-select of the stream bus carry no information here.
    assign unused_inputs = ^{s_adr, s_sel};

    // Registered ack with self-blocking term: at most one beat every two cycles.
    assign s_ack_next = s_cyc & s_stb & ~s_ack_reg & (~s_we | ~fifo_full);
    assign fifo_push  = s_ack_next & s_we;

    assign in_write = (state_reg == WRITE);
    assign fifo_pop = in_write & m_ack;
    assign last_pix = (pix_idx_reg == PW'(NPIX - 1));
    assign addr_off = 32'(pix_idx_reg) << 2;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .wdata     (s_dat_ms),
        .rdata     (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        state_next      = state_reg;
        pix_idx_next    = pix_idx_reg;
        frame_cnt_next  = frame_cnt_reg;
        frame_done_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                if (m_ack) begin
                    if (last_pix) begin
                        pix_idx_next    = '0;
                        frame_cnt_next  = frame_cnt_reg + 8'd1;
                        frame_done_next = 1'b1;
                    end else begin
                        pix_idx_next = pix_idx_reg + PW'(1);
                    end
                    // Keep the cycle open only if a word remains after this pop.
                    if (fifo_count == CW'(1) && !fifo_push) begin
                        state_next = IDLE;
                    end
                end else if (m_err) begin
                    // One idle cycle, then the same head word and address are retried.
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_reg      <= IDLE;
            pix_idx_reg    <= '0;
            frame_cnt_reg  <= '0;
            frame_done_reg <= 1'b0;
            s_ack_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pix_idx_reg    <= pix_idx_next;
            frame_cnt_reg  <= frame_cnt_next;
            frame_done_reg <= frame_done_next;
            s_ack_reg      <= s_ack_next;
        end
    end

    assign s_ack      = s_ack_reg;
    assign s_err      = 1'b0;
    assign s_rty      = 1'b0;
    assign s_dat_sm   = {frame_cnt_reg, 5'b00000, 19'(pix_idx_reg)};

    assign m_cyc      = in_write;
    assign m_stb      = in_write;
    assign m_we       = in_write;
    assign m_adr      = in_write ? (BASE_ADDR + addr_off) : 32'h0;
    assign m_dat_ms   = in_write ? fifo_rdata : 32'h0;
    assign m_sel      = 4'hF;
    assign m_cti      = CTI_CLASSIC;
    assign m_bte      = BTE_LINEAR;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_wshb_stream_writer.sv
// Directed bench for wshb_stream_writer with a small 4x2 frame and an SDRAM slave model.
module tb_wshb_stream_writer;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        s_cyc, s_stb, s_we;
    logic [31:0] s_adr, s_dat_ms;
    logic [3:0]  s_sel;
    logic [31:0] s_dat_sm;
    logic        s_ack, s_err, s_rty;
    logic        m_cyc, m_stb, m_we;
    logic [31:0] m_adr, m_dat_ms;
    logic [3:0]  m_sel;
    logic [2:0]  m_cti;
    logic [1:0]  m_bte;
    logic        m_ack, m_err;
    logic        frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    // SDRAM model configuration (written by the test sequence only)
    int hold_ack  = 0;
    int ack_delay = 0;
    int err_at    = -1;

    // SDRAM model observations (written by the model only)
    logic [63:0] wr_q[$];
    int          wait_cnt    = 0;
    int          err_done_at = -1;
    int          err_stage   = 0;
    int          fd_cnt      = 0;
    int          fd_at       = 0;
    logic [31:0] err_adr, err_dat, obs_adr, obs_dat;
    logic        obs_cyc_low, obs_cyc_back;

    wshb_stream_writer #(
        .HDISP      (4),
        .VDISP      (2),
        .BASE_ADDR  (32'h0),
        .FIFO_DEPTH (16)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .s_cyc      (s_cyc),
        .s_stb      (s_stb),
        .s_we       (s_we),
        .s_adr      (s_adr),
        .s_dat_ms   (s_dat_ms),
        .s_sel      (s_sel),
        .s_dat_sm   (s_dat_sm),
        .s_ack      (s_ack),
        .s_err      (s_err),
        .s_rty      (s_rty),
        .m_cyc      (m_cyc),
        .m_stb      (m_stb),
        .m_we       (m_we),
        .m_adr      (m_adr),
        .m_dat_ms   (m_dat_ms),
        .m_sel      (m_sel),
        .m_cti      (m_cti),
        .m_bte      (m_bte),
        .m_ack      (m_ack),
        .m_err      (m_err),
        .frame_done (frame_done)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // SDRAM slave: drives ack/err on negedges, logs every acked (adr, data).
    initial begin
        m_ack = 1'b0;
        m_err = 1'b0;
        forever begin
            @(negedge sys_clk);
            m_ack = 1'b0;
            m_err = 1'b0;
            if (frame_done === 1'b1) begin
                fd_cnt++;
                fd_at = wr_q.size();
            end
            if (err_stage == 1) begin
                obs_cyc_low = m_cyc;
                err_stage   = 2;
            end else if (err_stage == 2) begin
                obs_cyc_back = m_cyc;
                obs_adr      = m_adr;
                obs_dat      = m_dat_ms;
                err_stage    = 3;
            end
            if (sys_rst_n !== 1'b1 || m_stb !== 1'b1 || hold_ack != 0) begin
                wait_cnt = 0;
            end else if (wait_cnt < ack_delay) begin
                wait_cnt++;
            end else begin
                wait_cnt = 0;
                if (wr_q.size() == err_at && err_done_at != err_at) begin
                    m_err       = 1'b1;
                    err_done_at = err_at;
                    err_adr     = m_adr;
                    err_dat     = m_dat_ms;
                    err_stage   = 1;
                end else begin
                    m_ack = 1'b1;
                    wr_q.push_back({m_adr, m_dat_ms});
                end
            end
        end
    end

    task automatic wait_sack(input int budget, output bit got);
        got = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge sys_clk);
            if (s_ack === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic sb_write(input logic [31:0] data, output bit got);
        s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b1; s_dat_ms = data;
        wait_sack(40, got);
        s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0;
        $display("stream write %08h acked=%0d", data, got);
    endtask

    task automatic sb_read(output logic [31:0] data, output bit got);
        s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b0;
        wait_sack(40, got);
        data = s_dat_sm;
        s_cyc = 1'b0; s_stb = 1'b0;
        $display("status read %08h acked=%0d", data, got);
    endtask

    task automatic wait_records(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge sys_clk);
            if (wr_q.size() >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        hold_ack = 0; ack_delay = 0;
        s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0;
        sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b1; s_dat_ms = 32'h0011_2233;
        s_adr = 32'h0; s_sel = 4'hF;
        for (int c = 0; c < 3; c++) begin
            @(negedge sys_clk);
            n_checks++;
            if (s_ack !== 1'b0) begin n_fail++; $display("FAIL reset_s_ack cyc%0d got %b want 0", c, s_ack); end
            n_checks++;
            if (m_cyc !== 1'b0) begin n_fail++; $display("FAIL reset_m_cyc cyc%0d got %b want 0", c, m_cyc); end
            n_checks++;
            if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done cyc%0d got %b want 0", c, frame_done); end
        end
        n_checks++;
        if (m_sel !== 4'hF) begin n_fail++; $display("FAIL reset_m_sel got %h want f", m_sel); end
        n_checks++;
        if (s_dat_sm !== 32'h0) begin n_fail++; $display("FAIL reset_status got %08h want 00000000", s_dat_sm); end
        s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0;
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        $display("test_reset done");
    endtask

    task automatic test_single_write();
        int base;
        bit ok;
        logic [31:0] st;
        do_reset();
        ack_delay = 1;
        base = wr_q.size();
        s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b1; s_dat_ms = 32'h00FF_0000;
        @(negedge sys_clk);
        n_checks++;
        if (s_ack !== 1'b1) begin n_fail++; $display("FAIL single_ack_latency got %b want 1", s_ack); end
        s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0;
        wait_records(base + 1, 30, ok);
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL single_sdram_write got none want 1 record");
        end else begin
            n_checks++;
            if (wr_q[base] !== {32'h0, 32'h00FF_0000})
                begin n_fail++; $display("FAIL single_adr_data got %016h want 0000000000ff0000", wr_q[base]); end
        end
        @(negedge sys_clk);
        n_checks++;
        if (m_cyc !== 1'b0) begin n_fail++; $display("FAIL single_cyc_after got %b want 0", m_cyc); end
        sb_read(st, ok);
        n_checks++;
        if (st !== 32'h0000_0001) begin n_fail++; $display("FAIL single_status got %08h want 00000001", st); end
        $display("test_single_write done");
    endtask

    task automatic test_backpressure();
        int base, acked, i;
        bit got, ok;
        do_reset();
        hold_ack = 1;
        base = wr_q.size();
        acked = 0;
        for (i = 0; i < 20; i++) begin
            s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b1; s_dat_ms = 32'h00A0_0000 + 32'(i);
            wait_sack(12, got);
            if (!got) break;
            acked++;
            s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0;
        end
        $display("backpressure accepted %0d words while stalled", acked);
        n_checks++;
        if (acked != 16) begin n_fail++; $display("FAIL bp_accept_count got %0d want 16", acked); end
        n_checks++;
        if (m_adr !== 32'h0 || m_dat_ms !== 32'h00A0_0000)
            begin n_fail++; $display("FAIL bp_hold_stable got %08h/%08h want 00000000/00a00000", m_adr, m_dat_ms); end
        hold_ack = 0;
        for (int k = acked; k < 20; k++) begin
            if (k != acked) begin
                s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b1;
            end
            s_dat_ms = 32'h00A0_0000 + 32'(k);
            wait_sack(40, got);
            s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0;
            n_checks++;
            if (!got) begin n_fail++; $display("FAIL bp_late_ack word%0d got 0 want 1", k); end
        end
        wait_records(base + 20, 300, ok);
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL bp_sdram_count got %0d want 20", wr_q.size() - base);
        end else begin
            for (int k = 0; k < 20; k++) begin
                n_checks++;
                if (wr_q[base+k] !== {32'(4 * (k % 8)), 32'h00A0_0000 + 32'(k)})
                    begin n_fail++; $display("FAIL bp_order word%0d got %016h want %08h%08h", k, wr_q[base+k], 32'(4 * (k % 8)), 32'h00A0_0000 + 32'(k)); end
            end
        end
        $display("test_backpressure done");
    endtask

    task automatic test_wrap();
        int base, fd_base;
        bit got, ok;
        logic [31:0] st;
        do_reset();
        base = wr_q.size();
        fd_base = fd_cnt;
        for (int k = 0; k < 9; k++) begin
            sb_write(32'h0000_1000 + 32'(k), got);
            n_checks++;
            if (!got) begin n_fail++; $display("FAIL wrap_stream_ack word%0d got 0 want 1", k); end
        end
        wait_records(base + 9, 100, ok);
        repeat (3) @(negedge sys_clk);
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL wrap_sdram_count got %0d want 9", wr_q.size() - base);
        end else begin
            for (int k = 0; k < 9; k++) begin
                n_checks++;
                if (wr_q[base+k][63:32] !== 32'(4 * (k % 8)))
                    begin n_fail++; $display("FAIL wrap_adr word%0d got %08h want %08h", k, wr_q[base+k][63:32], 32'(4 * (k % 8))); end
            end
        end
        n_checks++;
        if (fd_cnt - fd_base != 1) begin n_fail++; $display("FAIL wrap_frame_done_count got %0d want 1", fd_cnt - fd_base); end
        n_checks++;
        if (fd_at - base != 8) begin n_fail++; $display("FAIL wrap_frame_done_pos got ack%0d want ack8", fd_at - base); end
        sb_read(st, got);
        n_checks++;
        if (st !== 32'h0100_0001) begin n_fail++; $display("FAIL wrap_status got %08h want 01000001", st); end
        $display("test_wrap done");
    endtask

    task automatic test_error_retry();
        int base;
        bit got, ok;
        do_reset();
        base = wr_q.size();
        err_at = base + 2;
        for (int k = 0; k < 5; k++) begin
            sb_write(32'h00C0_0000 + 32'(k), got);
        end
        wait_records(base + 5, 100, ok);
        repeat (3) @(negedge sys_clk);
        n_checks++;
        if (err_stage != 3) begin n_fail++; $display("FAIL err_injected got stage %0d want 3", err_stage); end
        n_checks++;
        if (obs_cyc_low !== 1'b0) begin n_fail++; $display("FAIL err_cyc_drop got %b want 0", obs_cyc_low); end
        n_checks++;
        if (obs_cyc_back !== 1'b1) begin n_fail++; $display("FAIL err_cyc_back got %b want 1", obs_cyc_back); end
        n_checks++;
        if (obs_adr !== 32'h8 || obs_dat !== 32'h00C0_0002)
            begin n_fail++; $display("FAIL err_reissue got %08h/%08h want 00000008/00c00002", obs_adr, obs_dat); end
        n_checks++;
        if (wr_q.size() - base != 5) begin
            n_fail++; $display("FAIL err_word_count got %0d want 5", wr_q.size() - base);
        end else begin
            for (int k = 0; k < 5; k++) begin
                n_checks++;
                if (wr_q[base+k] !== {32'(4 * k), 32'h00C0_0000 + 32'(k)})
                    begin n_fail++; $display("FAIL err_order word%0d got %016h", k, wr_q[base+k]); end
            end
        end
        $display("test_error_retry done");
    endtask

    task automatic test_reset_mid_transfer();
        int base;
        bit got, ok;
        do_reset();
        hold_ack = 1;
        base = wr_q.size();
        for (int k = 0; k < 5; k++) begin
            sb_write(32'h00D0_0000 + 32'(k), got);
        end
        @(negedge sys_clk);
        n_checks++;
        if (m_stb !== 1'b1) begin n_fail++; $display("FAIL mid_precond_stb got %b want 1", m_stb); end
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        n_checks++;
        if (m_cyc !== 1'b0) begin n_fail++; $display("FAIL mid_cyc_drop got %b want 0", m_cyc); end
        sys_rst_n = 1'b1;
        hold_ack = 0;
        repeat (10) @(negedge sys_clk);
        n_checks++;
        if (wr_q.size() != base || m_cyc !== 1'b0)
            begin n_fail++; $display("FAIL mid_fifo_flushed got %0d writes cyc=%b want 0 writes cyc=0", wr_q.size() - base, m_cyc); end
        sb_write(32'h0012_3456, got);
        wait_records(base + 1, 40, ok);
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL mid_next_write got none want 1 record");
        end else begin
            n_checks++;
            if (wr_q[base] !== {32'h0, 32'h0012_3456})
                begin n_fail++; $display("FAIL mid_next_adr got %016h want 0000000000123456", wr_q[base]); end
        end
        $display("test_reset_mid_transfer done");
    endtask

    initial begin
        s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0;
        s_adr = 32'h0; s_dat_ms = 32'h0; s_sel = 4'hF;
        sys_rst_n = 1'b0;
        test_reset();
        test_single_write();
        test_backpressure();
        test_wrap();
        test_error_retry();
        test_reset_mid_transfer();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
